// File: rtl/risc_pkg.sv
// Shared types for the load/store unit: operation codes, FSM states and
// the default access timeout.
package risc_pkg;

    typedef enum logic [3:0] {
        LSU_NONE = 4'd0,
        LSU_LB   = 4'd1,
        LSU_LH   = 4'd2,
        LSU_LW   = 4'd3,
        LSU_LBU  = 4'd4,
        LSU_LHU  = 4'd5,
        LSU_SB   = 4'd6,
        LSU_SH   = 4'd7,
        LSU_SW   = 4'd8
    } op_enum_lsu;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_WAIT = 2'd1,
        LSU_DONE = 2'd2
    } lsu_state_e;

    localparam int LSU_TIMEOUT_DEF = 16;

    // True for the three store operations.
    function automatic logic lsu_is_store(input op_enum_lsu op);
        return (op == LSU_SB) || (op == LSU_SH) || (op == LSU_SW);
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane logic: store byte enables and lane replication,
// alignment check, and load byte/half extraction with sign/zero extension.
module lsu_align
    import risc_pkg::*;
(
    input  op_enum_lsu  op,
    input  logic [1:0]  off,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_lane,
    output logic [31:0] load_data,
    output logic        misalign
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane selection: halves can only sit at offset 0 or 2 once aligned.
    always_comb begin
        byte_sel = rdata[{off, 3'b000} +: 8];
        half_sel = off[1] ? rdata[31:16] : rdata[15:0];
    end

    // Per-operation enables, replication, extension and alignment.
    always_comb begin
        be         = 4'hF;
        wdata_lane = wdata;
        load_data  = 32'h0;
        misalign   = 1'b0;
        case (op)
            LSU_SB: begin
                be         = 4'b0001 << off;
                wdata_lane = {4{wdata[7:0]}};
            end
            LSU_SH: begin
                be         = 4'b0011 << off;
                wdata_lane = {2{wdata[15:0]}};
                misalign   = off[0];
            end
            LSU_SW: misalign = |off;
            LSU_LB:  load_data = {{24{byte_sel[7]}}, byte_sel};
            LSU_LBU: load_data = {24'h0, byte_sel};
            LSU_LH: begin
                load_data = {{16{half_sel[15]}}, half_sel};
                misalign  = off[0];
            end
            LSU_LHU: begin
                load_data = {16'h0, half_sel};
                misalign  = off[0];
            end
            LSU_LW: begin
                load_data = rdata;
                misalign  = |off;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Multi-cycle load/store unit: one req/ack memory access per instruction,
// with alignment checking, byte lanes, load extension and an ack timeout.
module lsu
    import risc_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int TIMEOUT_CYC = LSU_TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              lsu_start,
    input  op_enum_lsu        lsu_op,
    input  logic [XLEN-1:0]   lsu_addr,
    input  logic [XLEN-1:0]   lsu_wdata,
    output logic              lsu_busy,
    output logic              lsu_done,
    output logic [XLEN-1:0]   lsu_rdata,
    output logic              lsu_misalign,
    output logic              lsu_fault,
    output logic              mem_req,
    output logic              mem_we,
    output logic [XLEN-1:0]   mem_addr,
    output logic [XLEN/8-1:0] mem_be,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic              mem_ack,
    input  logic [XLEN-1:0]   mem_rdata
);

    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    lsu_state_e        state_q, state_d;
    op_enum_lsu        op_q, op_d;
    logic [1:0]        off_q, off_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              misalign_q, misalign_d;
    logic              fault_q, fault_d;
    logic [XLEN-1:0]   rdata_q, rdata_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [XLEN-1:0]   mem_addr_q, mem_addr_d;
    logic [XLEN/8-1:0] mem_be_q, mem_be_d;
    logic [XLEN-1:0]   mem_wdata_q, mem_wdata_d;

    // The aligner sees the live request while idle and the latched one after.
    op_enum_lsu        al_op;
    logic [1:0]        al_off;
    logic [3:0]        al_be;
    logic [31:0]       al_wdata;
    logic [31:0]       al_load;
    logic              al_misalign;

    // Operand select for the shared aligner.
    always_comb begin
        al_op  = (state_q == LSU_IDLE) ? lsu_op : op_q;
        al_off = (state_q == LSU_IDLE) ? lsu_addr[1:0] : off_q;
    end

    lsu_align u_align (
        .op         (al_op),
        .off        (al_off),
        .wdata      (lsu_wdata),
        .rdata      (mem_rdata),
        .be         (al_be),
        .wdata_lane (al_wdata),
        .load_data  (al_load),
        .misalign   (al_misalign)
    );

    // Next-state and registered-output computation.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        off_d       = off_q;
        cnt_d       = cnt_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        misalign_d  = misalign_q;
        fault_d     = fault_q;
        rdata_d     = rdata_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_be_d    = mem_be_q;
        mem_wdata_d = mem_wdata_q;
        case (state_q)
            LSU_IDLE: begin
                if (lsu_start && (lsu_op != LSU_NONE)) begin
                    op_d       = lsu_op;
                    off_d      = lsu_addr[1:0];
                    cnt_d      = '0;
                    busy_d     = 1'b1;
                    misalign_d = 1'b0;
                    fault_d    = 1'b0;
                    if (al_misalign) begin
                        // No memory access: complete straight away.
                        state_d    = LSU_DONE;
                        misalign_d = 1'b1;
                        done_d     = 1'b1;
                        rdata_d    = '0;
                    end else begin
                        state_d     = LSU_WAIT;
                        mem_req_d   = 1'b1;
                        mem_we_d    = lsu_is_store(lsu_op);
                        mem_addr_d  = {lsu_addr[XLEN-1:2], 2'b00};
                        mem_be_d    = al_be;
                        mem_wdata_d = al_wdata;
                    end
                end
            end
            LSU_WAIT: begin
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    state_d   = LSU_DONE;
                    done_d    = 1'b1;
                    rdata_d   = lsu_is_store(op_q) ? '0 : al_load;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                    mem_req_d = 1'b0;
                    fault_d   = 1'b1;
                    rdata_d   = '0;
                    state_d   = LSU_DONE;
                    done_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            LSU_DONE: begin
                state_d = LSU_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d   = LSU_IDLE;
                busy_d    = 1'b0;
                mem_req_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset drops any access in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= LSU_IDLE;
            op_q        <= LSU_NONE;
            off_q       <= '0;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            misalign_q  <= 1'b0;
            fault_q     <= 1'b0;
            rdata_q     <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            off_q       <= off_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            misalign_q  <= misalign_d;
            fault_q     <= fault_d;
            rdata_q     <= rdata_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign lsu_busy     = busy_q;
    assign lsu_done     = done_q;
    assign lsu_rdata    = rdata_q;
    assign lsu_misalign = misalign_q;
    assign lsu_fault    = fault_q;
    assign mem_req      = mem_req_q;
    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_be       = mem_be_q;
    assign mem_wdata    = mem_wdata_q;

endmodule

// File: tb/tb_lsu.sv
// Bench for lsu: vector table plus hand sequences, with a scoreboard that
// checks completion results against expectations queued at issue time.
module tb_lsu;
    import risc_pkg::*;

    localparam int TMO = 16;

    logic        clk;
    logic        rst_n;
    logic        lsu_start;
    op_enum_lsu  lsu_op;
    logic [31:0] lsu_addr;
    logic [31:0] lsu_wdata;
    logic        lsu_busy;
    logic        lsu_done;
    logic [31:0] lsu_rdata;
    logic        lsu_misalign;
    logic        lsu_fault;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    lsu #(.XLEN(32), .TIMEOUT_CYC(TMO)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .lsu_start    (lsu_start),
        .lsu_op       (lsu_op),
        .lsu_addr     (lsu_addr),
        .lsu_wdata    (lsu_wdata),
        .lsu_busy     (lsu_busy),
        .lsu_done     (lsu_done),
        .lsu_rdata    (lsu_rdata),
        .lsu_misalign (lsu_misalign),
        .lsu_fault    (lsu_fault),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_be       (mem_be),
        .mem_wdata    (mem_wdata),
        .mem_ack      (mem_ack),
        .mem_rdata    (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] rd;
        logic        mis;
        logic        flt;
    } sb_t;
    sb_t sb_q[$];
    sb_t mon_e;

    typedef struct {
        op_enum_lsu  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          dly;     // ack after this many req cycles; -1 = never
        logic [3:0]  be;
        logic [31:0] exp_wd;
        logic [31:0] exp_rd;
        logic        mis;
        logic        flt;
    } vec_t;

    // Memory responder: ack once req has been up for ack_delay cycles.
    int          req_cycles = 0;
    int          ack_delay  = 0;
    logic        ack_en     = 1'b0;
    logic [31:0] rsp_rdata  = 32'h0;
    always @(posedge clk) req_cycles <= mem_req ? req_cycles + 1 : 0;
    assign mem_ack   = mem_req && ack_en && (req_cycles == ack_delay);
    assign mem_rdata = rsp_rdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h want=0x%08h", name, act, exp);
        end
    endtask

    // Scoreboard: every completion pops the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && lsu_done) begin
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got=1 want=0");
            end else begin
                mon_e = sb_q.pop_front();
                chk("rdata", lsu_rdata, mon_e.rd);
                chk("misalign", {31'h0, lsu_misalign}, {31'h0, mon_e.mis});
                chk("fault", {31'h0, lsu_fault}, {31'h0, mon_e.flt});
                chk("busy_in_done", {31'h0, lsu_busy}, 32'h1);
                $display("done: rdata=0x%08h mis=%0b flt=%0b", lsu_rdata, lsu_misalign, lsu_fault);
            end
        end
    end

    task automatic run_vec(input vec_t v, input bit spam);
        int          cyc;
        int          reqs;
        int          unstable;
        int          exp_lat;
        logic [31:0] a0;
        logic [31:0] w0;
        logic [3:0]  b0;
        logic        we0;
        logic        is_st;
        sb_t         e;
        is_st = (v.op == LSU_SB) || (v.op == LSU_SH) || (v.op == LSU_SW);
        exp_lat = v.mis ? 0 : (v.flt ? TMO : v.dly + 1);
        @(negedge clk);
        rsp_rdata = v.rdata;
        ack_en    = (v.dly >= 0);
        ack_delay = v.dly;
        lsu_start = 1'b1;
        lsu_op    = v.op;
        lsu_addr  = v.addr;
        lsu_wdata = v.wdata;
        e.rd = v.exp_rd; e.mis = v.mis; e.flt = v.flt;
        sb_q.push_back(e);
        @(negedge clk);
        lsu_start = spam;
        lsu_op    = spam ? LSU_SW : LSU_NONE;
        lsu_addr  = 32'h0000_0F00;
        if (!v.mis) begin
            chk("req_addr", mem_addr, v.addr & 32'hFFFF_FFFC);
            chk("req_be", {28'h0, mem_be}, {28'h0, v.be});
            chk("req_we", {31'h0, mem_we}, {31'h0, is_st});
            if (is_st) chk("req_wdata", mem_wdata, v.exp_wd);
        end
        a0 = mem_addr; w0 = mem_wdata; b0 = mem_be; we0 = mem_we;
        cyc = 0; reqs = 0; unstable = 0;
        while (!lsu_done && cyc < 40) begin
            if (mem_req) begin
                reqs++;
                if (mem_addr !== a0 || mem_wdata !== w0 || mem_be !== b0 || mem_we !== we0)
                    unstable++;
            end
            @(negedge clk);
            cyc++;
        end
        lsu_start = 1'b0;
        lsu_op    = LSU_NONE;
        if (!lsu_done && sb_q.size() > 0) void'(sb_q.pop_back());
        chk("done_latency", cyc, exp_lat);
        chk("req_cycles", reqs, v.mis ? 0 : exp_lat);
        chk("req_stable", unstable, 0);
        $display("txn op=%0d addr=0x%08h lat=%0d reqs=%0d", v.op, v.addr, cyc, reqs);
    endtask

    vec_t vecs[13];

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{LSU_SW,  32'h100, 32'hDEADBEEF, 32'h0,         0, 4'hF,    32'hDEADBEEF, 32'h0,         1'b0, 1'b0};
        vecs[1]  = '{LSU_LB,  32'h103, 32'h0,        32'h80FF_0000, 0, 4'hF,    32'h0,        32'hFFFF_FF80, 1'b0, 1'b0};
        vecs[2]  = '{LSU_LBU, 32'h103, 32'h0,        32'h80FF_0000, 1, 4'hF,    32'h0,        32'h0000_0080, 1'b0, 1'b0};
        vecs[3]  = '{LSU_LH,  32'h102, 32'h0,        32'h80FF_0000, 2, 4'hF,    32'h0,        32'hFFFF_80FF, 1'b0, 1'b0};
        vecs[4]  = '{LSU_LHU, 32'h102, 32'h0,        32'h80FF_0000, 0, 4'hF,    32'h0,        32'h0000_80FF, 1'b0, 1'b0};
        vecs[5]  = '{LSU_SB,  32'h101, 32'h0000_00AB, 32'h0,        0, 4'b0010, 32'hABAB_ABAB, 32'h0,        1'b0, 1'b0};
        vecs[6]  = '{LSU_SH,  32'h102, 32'h0000_1234, 32'h0,        3, 4'b1100, 32'h1234_1234, 32'h0,        1'b0, 1'b0};
        vecs[7]  = '{LSU_LW,  32'h102, 32'h0,        32'h0,         0, 4'hF,    32'h0,        32'h0,         1'b1, 1'b0};
        vecs[8]  = '{LSU_SH,  32'h101, 32'h5555,     32'h0,         0, 4'hF,    32'h0,        32'h0,         1'b1, 1'b0};
        vecs[9]  = '{LSU_LW,  32'h104, 32'h0,        32'h80FF_0000, 5, 4'hF,    32'h0,        32'h80FF_0000, 1'b0, 1'b0};
        vecs[10] = '{LSU_LW,  32'h108, 32'h0,        32'h0,        -1, 4'hF,    32'h0,        32'h0,         1'b0, 1'b1};
        vecs[11] = '{LSU_LB,  32'h100, 32'h0,        32'h1234_567F, 0, 4'hF,    32'h0,        32'h0000_007F, 1'b0, 1'b0};
        vecs[12] = '{LSU_LH,  32'h100, 32'h0,        32'h1234_F00D, 1, 4'hF,    32'h0,        32'hFFFF_F00D, 1'b0, 1'b0};

        rst_n = 1'b0; lsu_start = 1'b0; lsu_op = LSU_NONE;
        lsu_addr = 32'h0; lsu_wdata = 32'h0;
        repeat (2) @(negedge clk);
        chk("rst_busy", {31'h0, lsu_busy}, 32'h0);
        chk("rst_done", {31'h0, lsu_done}, 32'h0);
        chk("rst_rdata", lsu_rdata, 32'h0);
        chk("rst_flags", {30'h0, lsu_misalign, lsu_fault}, 32'h0);
        chk("rst_req", {31'h0, mem_req}, 32'h0);
        chk("rst_mem", mem_addr | mem_wdata | {28'h0, mem_be}, 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++) run_vec(vecs[i], 1'b0);

        // Start pulses during a slow access must neither interrupt nor queue.
        run_vec('{LSU_LW, 32'h10C, 32'h0, 32'hCAFE_F00D, 5, 4'hF, 32'h0, 32'hCAFE_F00D, 1'b0, 1'b0}, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("no_queued_req", {30'h0, mem_req, lsu_busy}, 32'h0);
        end

        // LSU_NONE with start is ignored.
        @(negedge clk);
        lsu_start = 1'b1; lsu_op = LSU_NONE;
        @(negedge clk);
        lsu_start = 1'b0;
        chk("none_ignored", {30'h0, mem_req, lsu_busy}, 32'h0);
        @(negedge clk);
        chk("none_ignored2", {30'h0, mem_req, lsu_busy}, 32'h0);

        // Asynchronous reset while waiting for ack: access dropped, no done.
        @(negedge clk);
        ack_en = 1'b0;
        lsu_start = 1'b1; lsu_op = LSU_LW; lsu_addr = 32'h200;
        @(negedge clk);
        lsu_start = 1'b0; lsu_op = LSU_NONE;
        chk("pre_rst_req", {31'h0, mem_req}, 32'h1);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_req", {31'h0, mem_req}, 32'h0);
        chk("async_rst_busy", {31'h0, lsu_busy}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post_rst_idle", {29'h0, lsu_done, mem_req, lsu_busy}, 32'h0);
        end

        chk("sb_empty", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
